// File: rtl/tuple_pipe_pkg.sv
// Shared definitions for the tuple delay sink.
// Holds the default latency, FIFO depth and result width, plus the result type
// used by anything that handles a single tuple result at the default width.
package tuple_pipe_pkg;

  localparam int unsigned LatencyDefault = 3;
  localparam int unsigned DepthDefault   = 4;
  localparam int unsigned WidthDefault   = 8;

  typedef logic [WidthDefault-1:0] result_t;

endpackage

// File: rtl/tuple_fifo.sv
// Synchronous show-ahead FIFO for matured tuple results.
//
// Ports:
//   clk_i        sole clock, rising edge
//   rst_i        synchronous active-high reset (clears pointers and count)
//   push_i       write push_data_i at this edge (ignored when full)
//   push_data_i  data to write
//   pop_i        advance the head at this edge (ignored when empty)
//   valid_o      head holds a valid entry
//   data_o       head entry, zero while empty
//   count_o      occupancy, 0..DEPTH
module tuple_fifo
  import tuple_pipe_pkg::*;
#(
  parameter int unsigned DEPTH = DepthDefault,
  parameter int unsigned WIDTH = WidthDefault,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [CntW-1:0]  count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             empty, full;
  logic             push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(DEPTH));
  assign push_ok = push_i & ~full;
  assign pop_ok  = pop_i & ~empty;

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    count_d = count_q + CntW'(push_ok) - CntW'(pop_ok);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is visible until the count says so.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Head is masked while empty so the output reads zero out of reset.
  assign valid_o = ~empty;
  assign data_o  = empty ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/tuple_delay_sink.sv
// Credit-controlled sink for a fixed-latency, non-stalling delay stage.
// Each accepted issue launches a marker down a LATENCY-deep valid shift
// register; when the marker reaches the top bit, the stage's result on
// pipe_data_i is captured into a show-ahead FIFO. Issues are only granted
// while buffered plus in-flight results leave room in the FIFO.
//
// Ports:
//   clk_i        sole clock, rising edge
//   rst_i        synchronous active-high reset
//   in_valid_i   producer wants to issue a tuple this cycle
//   in_ready_o   credit available (issue = in_valid_i & in_ready_o)
//   pipe_data_i  result from the delay stage, sampled when a marker matures
//   out_valid_o  FIFO head valid
//   out_data_o   FIFO head data
//   out_ready_i  consumer takes the head when out_valid_o is high
//   count_o      FIFO occupancy
//   proto_err_o  sticky: in_valid_i was seen while in_ready_o was low
module tuple_delay_sink
  import tuple_pipe_pkg::*;
#(
  parameter int unsigned LATENCY = LatencyDefault,
  parameter int unsigned DEPTH   = DepthDefault,
  parameter int unsigned WIDTH   = WidthDefault,
  localparam int unsigned CntW   = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] pipe_data_i,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o,
  input  logic             out_ready_i,
  output logic [CntW-1:0]  count_o,
  output logic             proto_err_o
);

  logic [LATENCY-1:0] valid_sr_q, valid_sr_d;
  logic               proto_err_q, proto_err_d;
  logic               issue;
  logic               push;
  logic               pop;
  int unsigned        inflight;
  int unsigned        credits_used;

  // Credit check uses registered state only, so a pop this cycle frees a
  // slot for issue only from the next cycle on.
  always_comb begin
    inflight = 0;
    for (int unsigned i = 0; i < LATENCY; i++) begin
      inflight = inflight + 32'(valid_sr_q[i]);
    end
    credits_used = 32'(count_o) + inflight;
    in_ready_o   = (credits_used < DEPTH);
  end

  assign issue = in_valid_i & in_ready_o;
  assign push  = valid_sr_q[LATENCY-1];
  assign pop   = out_valid_o & out_ready_i;

  always_comb begin
    valid_sr_d    = '0;
    valid_sr_d[0] = issue;
    for (int unsigned i = 1; i < LATENCY; i++) begin
      valid_sr_d[i] = valid_sr_q[i-1];
    end
    proto_err_d = proto_err_q | (in_valid_i & ~in_ready_o);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_sr_q  <= '0;
      proto_err_q <= 1'b0;
    end else begin
      valid_sr_q  <= valid_sr_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign proto_err_o = proto_err_q;

  tuple_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push),
    .push_data_i (pipe_data_i),
    .pop_i       (pop),
    .valid_o     (out_valid_o),
    .data_o      (out_data_o),
    .count_o     (count_o)
  );

endmodule

// File: tb/tb_tuple_delay_sink.sv
// Self-checking bench for tuple_delay_sink: directed scenarios plus random
// traffic, all compared against a queue-based reference model.
module tb_tuple_delay_sink;
  import tuple_pipe_pkg::*;

  localparam int unsigned Lat   = LatencyDefault;
  localparam int unsigned Depth = DepthDefault;
  localparam int unsigned CntW  = $clog2(Depth) + 1;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic            in_valid_i = 1'b0;
  logic            in_ready_o;
  result_t         pipe_data_i = '0;
  logic            out_valid_o;
  result_t         out_data_o;
  logic            out_ready_i = 1'b0;
  logic [CntW-1:0] count_o;
  logic            proto_err_o;

  tuple_delay_sink #(
    .LATENCY (Lat),
    .DEPTH   (Depth),
    .WIDTH   (WidthDefault)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .pipe_data_i (pipe_data_i),
    .out_valid_o (out_valid_o),
    .out_data_o  (out_data_o),
    .out_ready_i (out_ready_i),
    .count_o     (count_o),
    .proto_err_o (proto_err_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model: capture-edge numbers of tuples in flight, and the
  // results waiting for the consumer, in issue order.
  int unsigned inflight_q[$];
  result_t     exp_q[$];
  bit          m_err = 1'b0;
  int unsigned edge_n = 0;
  int unsigned obs_acc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at edge %0d", tag, obs, exp, edge_n);
    end
  endtask

  function automatic bit m_ready();
    return (exp_q.size() + inflight_q.size()) < Depth;
  endfunction

  // Apply the effect of the coming clock edge given the inputs now driven.
  task automatic model_edge();
    bit rdy, do_pop, do_cap;
    if (rst_i) begin
      inflight_q.delete();
      exp_q.delete();
      m_err = 1'b0;
    end else begin
      rdy    = m_ready();
      do_pop = (exp_q.size() != 0) && out_ready_i;
      do_cap = (inflight_q.size() != 0) && (inflight_q[0] == edge_n);
      if (in_valid_i && !rdy) m_err = 1'b1;
      if (do_pop) void'(exp_q.pop_front());
      if (do_cap) begin
        exp_q.push_back(pipe_data_i);
        void'(inflight_q.pop_front());
      end
      if (in_valid_i && rdy) inflight_q.push_back(edge_n + Lat);
    end
    edge_n++;
  endtask

  task automatic check_all();
    check("in_ready", in_ready_o, m_ready());
    check("out_valid", out_valid_o, exp_q.size() != 0);
    if (exp_q.size() != 0) check("out_data", out_data_o, exp_q[0]);
    check("count", count_o, exp_q.size());
    check("proto_err", proto_err_o, m_err);
  endtask

  task automatic step(input logic v, input logic r, input result_t pd, input logic rs);
    if (v && in_ready_o === 1'b1 && !rs) obs_acc++;
    in_valid_i  = v;
    out_ready_i = r;
    pipe_data_i = pd;
    rst_i       = rs;
    model_edge();
    @(posedge clk_i);
    @(negedge clk_i);
    check_all();
  endtask

  function automatic result_t rnd();
    return result_t'($urandom);
  endfunction

  initial begin
    @(negedge clk_i);
    step(1'b0, 1'b0, rnd(), 1'b1);
    step(1'b0, 1'b0, rnd(), 1'b1);
    check("rst_ready", in_ready_o, 1);
    check("rst_valid", out_valid_o, 0);
    check("rst_data", out_data_o, 0);
    check("rst_count", count_o, 0);
    check("rst_err", proto_err_o, 0);

    // Single issue; result 0x13 presented on the capture edge.
    for (int i = 0; i <= Lat; i++) begin
      step(i == 0, 1'b0, (i == Lat) ? result_t'(8'h13) : rnd(), 1'b0);
      if (i < Lat) check("lat_early", out_valid_o, 0);
    end
    check("lat_valid", out_valid_o, 1);
    check("lat_data", out_data_o, 8'h13);
    check("lat_count", count_o, 1);

    // Fill: hold in_valid_i high with consumer stalled.
    step(1'b0, 1'b0, rnd(), 1'b1);
    obs_acc = 0;
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, rnd(), 1'b0);
    check("fill_accepts", obs_acc, Depth);
    check("fill_count", count_o, Depth);
    check("fill_ready", in_ready_o, 0);
    check("err_set", proto_err_o, 1);

    // One pop from full frees exactly one credit.
    obs_acc = 0;
    step(1'b1, 1'b1, rnd(), 1'b0);
    check("pop_ready", in_ready_o, 1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, rnd(), 1'b0);
    check("pop_accepts", obs_acc, 1);
    check("err_sticky", proto_err_o, 1);

    // Back-to-back order with consumer always ready.
    step(1'b0, 1'b0, rnd(), 1'b1);
    check("err_cleared", proto_err_o, 0);
    for (int i = 0; i < 6; i++) begin
      step(i < 3, 1'b1, (i >= 3) ? result_t'(i - 2) : rnd(), 1'b0);
      if (i >= 3) begin
        check("order_valid", out_valid_o, 1);
        check("order_data", out_data_o, i - 2);
      end
    end

    // Reset with two buffered and two in flight.
    step(1'b0, 1'b0, rnd(), 1'b1);
    for (int i = 0; i < 5; i++) step(i < 4, 1'b0, rnd(), 1'b0);
    check("mid_count", count_o, 2);
    step(1'b0, 1'b0, rnd(), 1'b1);
    check("mid_rst_valid", out_valid_o, 0);
    check("mid_rst_data", out_data_o, 0);
    check("mid_rst_count", count_o, 0);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, rnd(), 1'b0);
      check("no_stale", out_valid_o, 0);
    end

    // Random traffic with occasional resets.
    for (int i = 0; i < 500; i++) begin
      step(1'($urandom_range(0, 1)), ($urandom % 4) != 0, rnd(), ($urandom % 60) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tuple_delay_sink.md
TUPLE_DELAY_SINK -- requirements
Module: tuple_delay_sink

Interface
REQ-001 Parameter LATENCY, default 3: cycles from an accepted issue to pipe_data_i holding that tuple's result.
REQ-002 Parameter DEPTH, default 4: result FIFO entries (power of two, >=2).
REQ-003 Parameter WIDTH, default 8: result width.
REQ-004 Clocking fixed: one clock; reset is synchronous and active-high.
REQ-005 clk_i  input  1  sole clock, all state updates on rising edge.
REQ-006 rst_i  input  1  synchronous active-high reset.
REQ-007 in_valid_i  input  1  producer requests to issue a tuple into the delay stage this cycle.
REQ-008 in_ready_o  output  1  credit available; an issue counts only when in_valid_i and in_ready_o are both high.
REQ-009 pipe_data_i  input  WIDTH  result output of the upstream delay stage.
REQ-010 out_valid_o  output  1  FIFO head valid.
REQ-011 out_data_o  output  WIDTH  FIFO head data (show-ahead).
REQ-012 out_ready_i  input  1  consumer accepts head when high together with out_valid_o.
REQ-013 count_o  output  clog2(DEPTH)+1  FIFO occupancy.
REQ-014 proto_err_o  output  1  sticky; set when in_valid_i is high while in_ready_o is low.

Function
REQ-015 Issue = in_valid_i & in_ready_o; push a 1 into LATENCY-bit valid shift register (bit 0) on the same edge, 0 otherwise.
REQ-016 Valid shift register advances every cycle; no stall exists in the delay stage.
REQ-017 When the top bit is 1, pipe_data_i is written into the FIFO at the next edge (issue at edge k -> capture at edge k+LATENCY).
REQ-018 inflight = popcount of valid shift register; in_ready_o = (count_o + inflight) < DEPTH, combinational from registered state only.
REQ-019 Pop = out_valid_o & out_ready_i; head advances on that edge.
REQ-020 Simultaneous push and pop: both take effect; count_o unchanged; legal at full and at empty-plus-push is not bypassed.
REQ-021 No bypass: result captured at edge k+LATENCY appears on out_valid_o/out_data_o in the cycle after that edge; minimum issue-to-output latency LATENCY+1 edges.
REQ-022 Credit rule guarantees no FIFO overflow; a write to a full FIFO is unreachable and need not be handled.
REQ-023 Pointers wrap modulo DEPTH; count_o range 0..DEPTH.
REQ-024 Order preserved: outputs emerge in issue order.
REQ-025 out_data_o holds last head value when out_valid_o low is don't-care except after reset (see REQ-028).
REQ-026 proto_err_o, once set, stays set until reset; a rejected request has no other effect.

Reset
REQ-027 rst_i high at an edge clears valid shift register, FIFO pointers, count_o, proto_err_o.
REQ-028 After reset: in_ready_o=1, out_valid_o=0, out_data_o=0, count_o=0, proto_err_o=0.
REQ-029 Reset mid-operation discards in-flight and buffered results; pipe_data_i ignored until new issues mature.

Structure
REQ-030 Shared package tuple_pipe_pkg holds WIDTH, LATENCY, DEPTH defaults and the result type.
REQ-031 One sub-module tuple_fifo (sync show-ahead FIFO, push/pop/count); credit logic and valid shift register stay in the top.

Verification
REQ-032 Reset then single issue with upstream result 0x13 at capture edge -> out_valid_o high exactly LATENCY+1 edges after issue edge, out_data_o=0x13, count_o=1.
REQ-033 in_valid_i held high, out_ready_i low -> exactly DEPTH (4) issues accepted, in_ready_o low thereafter, count_o reaches 4 after last capture, no overflow.
REQ-034 Full FIFO, out_ready_i pulsed one cycle -> one pop, in_ready_o returns high next cycle, one further issue accepted.
REQ-035 Issues of results 0x01,0x02,0x03 back-to-back with out_ready_i high -> outputs 0x01,0x02,0x03 in order on consecutive cycles.
REQ-036 in_valid_i high while in_ready_o low -> proto_err_o=1 next cycle, stays 1, cleared only by rst_i.
REQ-037 rst_i asserted with 2 in flight and 2 buffered -> all outputs at reset values next cycle; no stale result ever emitted.
